key_press_gen: RTL and testbench



---
 rtl/key_press_gen.sv | 137 +++++++++++++
 tb/tb_key_press_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_press_gen.sv
// key_press_gen: emulates an active-low pushbutton from one-cycle request strobes.
// Each accepted request gives PRESS_CYCLES low cycles followed by GAP_CYCLES high
// cycles. Optional feature macro: PRESS_QUEUE_EN adds a saturating pending-request
// counter so requests arriving while busy are replayed back-to-back.
module key_press_gen #(
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int CNT_W        = 8,
  parameter int QDEPTH_W     = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                trigger,
  output logic                key_out,
  output logic                busy,
  output logic                done,
  output logic [QDEPTH_W-1:0] pending,
  output logic                dropped
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             in_busy;
  logic             gap_last;
  logic             restart;
  logic             drop_req;

  // Moore decode of the outputs straight from the state and counter registers
  always_comb begin
    in_busy  = (state == PRESS) || (state == GAP);
    gap_last = (state == GAP) && (cnt == CNT_ZERO);
    key_out  = (state != PRESS);
    busy     = in_busy;
    done     = gap_last;
  end

`ifdef PRESS_QUEUE_EN
  localparam logic [QDEPTH_W-1:0] Q_MAX  = {QDEPTH_W{1'b1}};
  localparam logic [QDEPTH_W-1:0] Q_ZERO = {QDEPTH_W{1'b0}};
  localparam logic [QDEPTH_W-1:0] Q_ONE  = QDEPTH_W'(1);

  logic [QDEPTH_W-1:0] pend;

  // On the last gap cycle a fresh trigger or a queued request starts the next press
  // immediately; a trigger there cancels against the dequeue, so it is never a drop.
  always_comb begin
    restart  = gap_last && (trigger || (pend != Q_ZERO));
    drop_req = trigger && in_busy && !gap_last && (pend == Q_MAX);
  end

  // Pending-request counter: enqueue while busy, dequeue on restart, saturate at max
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend <= Q_ZERO;
    end else if (gap_last) begin
      if (!trigger && (pend != Q_ZERO)) begin
        pend <= pend - Q_ONE;
      end else begin
        pend <= pend;
      end
    end else if (trigger && in_busy && (pend != Q_MAX)) begin
      pend <= pend + Q_ONE;
    end else begin
      pend <= pend;
    end
  end

  assign pending = pend;
`else
  // Without the queue every request made while busy is discarded
  always_comb begin
    restart  = 1'b0;
    drop_req = trigger && in_busy;
  end

  assign pending = {QDEPTH_W{1'b0}};
`endif

  // Main press/gap sequencer with registered drop flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= CNT_ZERO;
      dropped <= 1'b0;
    end else begin
      dropped <= drop_req;
      case (state)
        IDLE: begin
          if (trigger) begin
            state <= PRESS;
            cnt   <= PRESS_LOAD;
          end else begin
            state <= IDLE;
            cnt   <= cnt;
          end
        end
        PRESS: begin
          if (cnt == CNT_ZERO) begin
            state <= GAP;
            cnt   <= GAP_LOAD;
          end else begin
            state <= PRESS;
            cnt   <= cnt - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt != CNT_ZERO) begin
            state <= GAP;
            cnt   <= cnt - CNT_ONE;
          end else if (restart) begin
            state <= PRESS;
            cnt   <= PRESS_LOAD;
          end else begin
            state <= IDLE;
            cnt   <= CNT_ZERO;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_press_gen.sv
// Self-checking bench for key_press_gen: a position-in-press reference model is
// compared against the DUT every cycle, plus literal timeline checks and random traffic.
module tb_key_press_gen;

  localparam int P    = 4;
  localparam int G    = 4;
  localparam int QW   = 2;
  localparam int QMAX = 3;
`ifdef PRESS_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic          clock   = 1'b0;
  logic          reset   = 1'b1;
  logic          trigger = 1'b0;
  logic          key_out;
  logic          busy;
  logic          done;
  logic [QW-1:0] pending;
  logic          dropped;

  int checks = 0;
  int errors = 0;

  key_press_gen #(
    .PRESS_CYCLES(P),
    .GAP_CYCLES  (G),
    .CNT_W       (8),
    .QDEPTH_W    (QW)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .trigger(trigger),
    .key_out(key_out),
    .busy   (busy),
    .done   (done),
    .pending(pending),
    .dropped(dropped)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position inside the current press (0 idle, 1..P+G busy),
  // queued request count and the drop flag due next cycle
  int m_pos  = 0;
  int m_pend = 0;
  bit m_drop = 1'b0;

  // Advance the reference model on each clock edge from the sampled trigger
  always @(posedge clock or posedge reset) begin : model
    int np;
    int nq;
    bit nd;
    if (reset) begin
      m_pos  <= 0;
      m_pend <= 0;
      m_drop <= 1'b0;
    end else begin
      np = m_pos;
      nq = m_pend;
      nd = 1'b0;
      if (m_pos == 0) begin
        if (trigger) np = 1;
      end else if (m_pos == P + G) begin
        if (QEN && trigger) begin
          np = 1;
        end else if (m_pend > 0) begin
          np = 1;
          nq = m_pend - 1;
        end else begin
          np = 0;
          nd = trigger;
        end
      end else begin
        np = m_pos + 1;
        if (trigger) begin
          if (QEN && m_pend < QMAX) nq = m_pend + 1;
          else nd = 1'b1;
        end
      end
      m_pos  <= np;
      m_pend <= nq;
      m_drop <= nd;
    end
  end

  // Compare every DUT output against the model on each falling edge out of reset
  always @(negedge clock) begin
    if (!reset) begin
      check("key_out", key_out, (m_pos >= 1 && m_pos <= P) ? 0 : 1);
      check("busy",    busy,    (m_pos != 0) ? 1 : 0);
      check("done",    done,    (m_pos == P + G) ? 1 : 0);
      check("pending", pending, m_pend);
      check("dropped", dropped, m_drop);
    end
  end

  int   falls;
  int   drops;
  int   maxpend;
  logic prev_key;

  task automatic clear_tally();
    falls    = 0;
    drops    = 0;
    maxpend  = 0;
    prev_key = key_out;
  endtask

  task automatic step();
    @(negedge clock);
    if (prev_key === 1'b1 && key_out === 1'b0) falls++;
    if (dropped === 1'b1) drops++;
    if (int'(pending) > maxpend) maxpend = int'(pending);
    prev_key = key_out;
  endtask

  // One isolated trigger: literal timeline of low, busy and done cycles
  task automatic single_press(input string tag);
    int low_cnt, first_low, busy_cnt, done_cnt, done_at, mlow;
    low_cnt = 0; first_low = 0; busy_cnt = 0; done_cnt = 0; done_at = 0; mlow = 0;
    trigger = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 1) trigger = 1'b0;
      if (key_out === 1'b0) begin
        low_cnt++;
        if (first_low == 0) first_low = i;
      end
      if (m_pos >= 1 && m_pos <= P) mlow++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = i;
      end
    end
    check({tag, "_low_cycles"}, low_cnt, 4);
    check({tag, "_first_low"}, first_low, 1);
    check({tag, "_busy_cycles"}, busy_cnt, 8);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_at"}, done_at, 8);
    check({tag, "_model_low"}, mlow, 4);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin : stim
    bit found;
    int thresh;
    int rst_at;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_key_out", key_out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pending", pending, 0);
    check("rst_dropped", dropped, 0);
    reset = 1'b0;
    repeat (2) step();

    // Single press timeline
    single_press("single");
    repeat (3) step();

    // Three triggers two cycles apart
    clear_tally();
    for (int k = 0; k < 3; k++) begin
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      step();
    end
    repeat (30) step();
    check("spaced_presses", falls, QEN ? 3 : 1);
    check("spaced_maxpend", maxpend, QEN ? 2 : 0);
    check("spaced_drops", drops, QEN ? 0 : 2);
    repeat (3) step();

    // Trigger held six cycles, then a trigger on the final gap cycle
    clear_tally();
    trigger = 1'b1;
    repeat (6) step();
    trigger = 1'b0;
    check("hold_maxpend", maxpend, QEN ? 3 : 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (done === 1'b1) found = 1'b1;
    end
    check("hold_done_seen", found, 1);
    check("coinc_pending_before", pending, QEN ? 3 : 0);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    check("coinc_pending_after", pending, QEN ? 3 : 0);
    check("coinc_dropped", dropped, QEN ? 0 : 1);
    check("coinc_no_idle", key_out, QEN ? 0 : 1);
    repeat (50) step();
    check("hold_presses", falls, QEN ? 5 : 1);
    check("hold_drops", drops, QEN ? 2 : 6);
    check("hold_idle_after", busy, 0);

    // Reset on the second press cycle must release key_out without a clock edge
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    check("midrst_pressing", key_out, 0);
    #2 reset = 1'b1;
    #1;
    check("midrst_key_out", key_out, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pending", pending, 0);
    check("midrst_dropped", dropped, 0);
    repeat (2) step();
    reset = 1'b0;
    repeat (2) step();
    single_press("after_reset");

    // Random traffic in bursts of varying density, with one reset mid-run
    rst_at = $urandom_range(800, 2200);
    thresh = 10;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        case ($urandom_range(0, 2))
          0: thresh = 5;
          1: thresh = 25;
          default: thresh = 70;
        endcase
      end
      trigger = ($urandom_range(0, 99) < thresh);
      if (c == rst_at) begin
        #2 reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end
    trigger = 1'b0;
    repeat (60) step();
    check("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
